gray_ssi_tx: RTL
================

Name: gray_ssi_tx

Overview:
Position-sensor side of the Gray-coded position link. Latches a binary position, converts it to Gray code and shifts it out serially, MSB first, with its own serial clock. The same Gray word is also presented in parallel on a 32-bit bus. Sits in the 50 MHz domain and acts as the sensor emulator / transmitter whose output feeds the Gray-to-binary receive path.

Parameters:
DATA_W, 25, valid position bits (1..32); bits above DATA_W are ignored on input and driven 0 on gray_out.
HALF_DIV, 25, clk cycles per ser_clk half-period (50 MHz -> 1 MHz serial); minimum 2.
MONO_CYC, 1000, clk cycles of line-quiet time after the last bit before a new frame is accepted (20 us).

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-low
pos_in  in  32  binary position
send_req  in  1  frame request strobe, sampled when idle
busy  out  1  frame in progress or line-quiet time running
gray_out  out  32  latched Gray word, zero-extended above DATA_W
ser_clk  out  1  serial clock, idles high
ser_data  out  1  serial data, idles high
done  out  1  one-cycle pulse when the frame's last bit period ends

Behaviour:
- Reset (rst=0, asynchronous):
  - gray_out=0, done=0, busy=0.
  - ser_clk=1, ser_data=1.
  - FSM returns to IDLE and all counters clear.
- Conversion: g = b ^ (b >> 1) on b = pos_in[DATA_W-1:0]. Computed from the registered latch, not from live pos_in.
- FSM states: IDLE, LOAD, SHIFT, MONO.
- IDLE:
  - Lines are idle-high.
  - When send_req=1, latch pos_in and go to LOAD; busy=1 from the next cycle.
- LOAD, one cycle:
  - gray_out <= g.
  - Shift register <= g (DATA_W bits).
  - Bit counter <= DATA_W (+1 with PARITY_EN).
  - Go to SHIFT.
- SHIFT:
  - Each bit occupies 2*HALF_DIV cycles.
  - ser_clk goes low for the first HALF_DIV cycles and high for the second.
  - ser_data is updated to the next bit, MSB first, on the cycle ser_clk falls, so it is stable at the rising edge.
  - After the final bit's high half-period: done pulses 1 cycle, ser_data returns to 1, go to MONO.
- MONO:
  - Counts MONO_CYC cycles with the lines idle-high, then goes to IDLE with busy=0.
- Latency:
  - send_req to first ser_clk fall: 2 cycles.
  - Frame length: 2*HALF_DIV*N + 2 cycles, where N = bits per frame.
- send_req while busy is ignored, not queued. send_req held high re-triggers on the first IDLE cycle after MONO.
- pos_in changes during a frame do not affect the frame in progress; gray_out holds until the next LOAD.
- Reset mid-frame aborts immediately: lines go idle-high and no done pulse is produced.
- DATA_W=32: full width; no zero extension.

Optional Feature:
PARITY_EN_EN is not used; the macro is GRAY_SSI_PARITY_EN.
- Defined: one extra bit follows the LSB, carrying even parity over the DATA_W Gray bits. Frame is DATA_W+1 bits; done fires after the parity bit.
- Undefined: frame is exactly DATA_W bits and no parity logic is present.

Decomposition:
- Shared package gray_pkg holds:
  - FSM state typedef: IDLE, LOAD, SHIFT, MONO.
  - Default constants: DATA_W, HALF_DIV, MONO_CYC.
  - bin_to_gray function, parameterised by width.
- One natural sub-module: ssi_clk_gen. It is the half-period divider that produces ser_clk plus fall/rise tick strobes, enabled only in SHIFT.

Test Plan:
- pos_in=5, send_req pulse, DATA_W=25 -> gray_out=0x0000007; ser_data bits MSB-first = 22 zeros then 1,1,1; done pulse after 25*50+2 cycles; busy low MONO_CYC cycles later.
- pos_in=0x1FFFFFF -> gray_out=0x1000000; first serial bit 1, remaining 24 bits 0.
- pos_in=0xFE000003 (upper bits set) -> gray_out=0x0000002; upper input bits ignored.
- send_req pulses at cycle 10 of SHIFT and during MONO -> no new frame, no extra done; held send_req starts a frame on the first IDLE cycle.
- rst asserted low mid-SHIFT at bit 12 -> ser_clk=1, ser_data=1, busy=0 and gray_out=0 within the same cycle; no done pulse.
- GRAY_SSI_PARITY_EN defined, pos_in=5 (gray 0x7, three ones) -> 26-bit frame ending in parity bit 1; done after 26*50+2 cycles.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types, defaults and helpers for the Gray-coded SSI position transmitter.
package gray_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      MONO  = 2'd3
   } state_t;

   localparam int DEF_DATA_W   = 25;
   localparam int DEF_HALF_DIV = 25;
   localparam int DEF_MONO_CYC = 1000;

   // All-ones in the low w bits (w = 1..32), zeros above.
   function automatic logic [31:0] width_mask(input int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return m[31:0];
   endfunction

   // Binary to reflected Gray over the low w bits; bits above w come out zero.
   function automatic logic [31:0] bin_to_gray(input logic [31:0] b, input int w);
      logic [31:0] bm;
      bm = b & width_mask(w);
      return bm ^ (bm >> 1);
   endfunction

endpackage

// File: rtl/ssi_clk_gen.sv
// Serial clock divider: while enabled, each bit period is 2*HALF_DIV cycles,
// ser_clk low for the first half and high for the second. fall_tick marks the
// cycle whose edge drops ser_clk; rise_tick the cycle whose edge raises it.
// hold suppresses the fall so the line stays high once the frame is complete.
module ssi_clk_gen
   import gray_pkg::*;
#(
   parameter int HALF_DIV = DEF_HALF_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic hold,
   output logic ser_clk,
   output logic fall_tick,
   output logic rise_tick
);

   localparam int CW = $clog2(2 * HALF_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * HALF_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          ser_clk_q, ser_clk_d;

   // Phase counter and next serial clock level; counter parks at zero when disabled.
   always_comb begin
      fall_tick = en && (cnt_q == '0);
      rise_tick = en && (cnt_q == CNT_HALF);
      cnt_d     = '0;
      ser_clk_d = 1'b1;
      if (en) begin
         cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         ser_clk_d = ser_clk_q;
         if (fall_tick && !hold) begin
            ser_clk_d = 1'b0;
         end else if (rise_tick) begin
            ser_clk_d = 1'b1;
         end
      end
   end

   // Divider state, clock idles high out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         ser_clk_q <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         ser_clk_q <= ser_clk_d;
      end
   end

   assign ser_clk = ser_clk_q;

endmodule

// File: rtl/gray_ssi_tx.sv
// Gray-coded SSI position transmitter: latches pos_in on send_req, converts it
// to Gray, shifts it out MSB first on ser_clk/ser_data and holds it on gray_out.
// After each frame the line stays quiet for MONO_CYC cycles before a new request.
// Build option: define GRAY_SSI_PARITY_EN to append an even-parity bit after the LSB.
module gray_ssi_tx
   import gray_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int HALF_DIV = DEF_HALF_DIV,
   parameter int MONO_CYC = DEF_MONO_CYC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pos_in,
   input  logic        send_req,
   output logic        busy,
   output logic [31:0] gray_out,
   output logic        ser_clk,
   output logic        ser_data,
   output logic        done
);

`ifdef GRAY_SSI_PARITY_EN
   localparam int N_BITS = DATA_W + 1;
`else
   localparam int N_BITS = DATA_W;
`endif
   localparam int BCW = $clog2(N_BITS + 1);
   localparam int MCW = $clog2(MONO_CYC + 1);
   localparam logic [BCW-1:0] N_BITS_L  = BCW'(N_BITS);
   localparam logic [MCW-1:0] MONO_LAST = MCW'(MONO_CYC - 1);
   localparam logic [31:0]    IN_MASK   = width_mask(DATA_W);

   state_t              state_q, state_d;
   logic [31:0]         lat_q, lat_d;
   logic [31:0]         gray_q, gray_d;
   logic [N_BITS-1:0]   sh_q, sh_d;
   logic [BCW-1:0]      bit_q, bit_d;
   logic [MCW-1:0]      mono_q, mono_d;
   logic                sdata_q, sdata_d;
   logic                done_q, done_d;

   logic [31:0]         gray_w;
   logic                clk_en, hold, fall_tick, rise_tick, ser_clk_w;

   // Conversion works on the latched word so pos_in may move freely mid-frame.
   assign gray_w = bin_to_gray(lat_q, DATA_W);

   ssi_clk_gen #(
      .HALF_DIV (HALF_DIV)
   ) u_clk_gen (
      .clk       (clk),
      .rst       (rst),
      .en        (clk_en),
      .hold      (hold),
      .ser_clk   (ser_clk_w),
      .fall_tick (fall_tick),
      .rise_tick (rise_tick)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a frame ends on the fall slot that finds no bits left.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (send_req) state_d = LOAD;
         LOAD:    state_d = SHIFT;
         SHIFT:   if (fall_tick && hold) state_d = MONO;
         MONO:    if (mono_q == MONO_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: divider runs only while shifting; hold once all bits are out.
   always_comb begin
      busy   = (state_q != IDLE);
      clk_en = (state_q == SHIFT);
      hold   = (bit_q == '0);
   end

   // Datapath next values: latch, load, shift on fall, count bits on rise, quiet timer.
   always_comb begin
      lat_d   = lat_q;
      gray_d  = gray_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      mono_d  = '0;
      sdata_d = 1'b1;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (send_req) lat_d = pos_in & IN_MASK;
         end
         LOAD: begin
            gray_d = gray_w;
`ifdef GRAY_SSI_PARITY_EN
            sh_d   = {gray_w[DATA_W-1:0], ^gray_w[DATA_W-1:0]};
`else
            sh_d   = gray_w[DATA_W-1:0];
`endif
            bit_d  = N_BITS_L;
         end
         SHIFT: begin
            sdata_d = sdata_q;
            if (fall_tick) begin
               if (hold) begin
                  sdata_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  sdata_d = sh_q[N_BITS-1];
                  sh_d    = sh_q << 1;
               end
            end
            if (rise_tick && !hold) bit_d = bit_q - 1'b1;
         end
         MONO: begin
            mono_d = mono_q + 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers; reset clears everything and idles the data line high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_q   <= '0;
         gray_q  <= '0;
         sh_q    <= '0;
         bit_q   <= '0;
         mono_q  <= '0;
         sdata_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         lat_q   <= lat_d;
         gray_q  <= gray_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         mono_q  <= mono_d;
         sdata_q <= sdata_d;
         done_q  <= done_d;
      end
   end

   assign gray_out = gray_q;
   assign ser_clk  = ser_clk_w;
   assign ser_data = sdata_q;
   assign done     = done_q;

endmodule
